// File: rtl/ps2_out.sv
// PS/2 host-to-device transmitter.
// Runs the request-to-send handshake on the shared open-drain lines, shifts out one
// command byte LSB first with odd parity and stop, then samples the device ack bit.
// busy_o covers the whole transfer so the receive path can stay idle meanwhile.
module ps2_out #(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned START_TIMEOUT  = 750000,
    parameter int unsigned XFER_TIMEOUT   = 100000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       send_cmd_i,
    input  logic [7:0] cmd_byte_i,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_drive_low_o,
    output logic       ps2_data_drive_low_o,
    output logic       busy_o,
    output logic       cmd_sent_o,
    output logic       error_o
);

    // One timer serves both the inhibit period and the RTS start timeout.
    localparam int unsigned TmrMax  = (INHIBIT_CYCLES > START_TIMEOUT) ? INHIBIT_CYCLES
                                                                       : START_TIMEOUT;
    localparam int unsigned TmrW    = $clog2(TmrMax + 1);
    localparam int unsigned XferW   = $clog2(XFER_TIMEOUT + 1);

    localparam logic [TmrW-1:0]  InhibitLast = TmrW'(INHIBIT_CYCLES - 1);
    localparam logic [TmrW-1:0]  StartLast   = TmrW'(START_TIMEOUT - 1);
    localparam logic [XferW-1:0] XferLast    = XferW'(XFER_TIMEOUT - 1);

    typedef enum logic [3:0] {
        StIdle,
        StInhibit,
        StRts,
        StSendData,
        StSendParity,
        StSendStop,
        StWaitAck,
        StWaitRelease,
        StAbort
    } state_e;

    state_e             state_q;
    logic [TmrW-1:0]    tmr_q;
    logic [XferW-1:0]   xfer_q;
    logic [2:0]         bit_cnt_q;
    logic [7:0]         shift_q;
    logic               parity_q;
    logic               ok_q;

    logic               clk_drv_q;
    logic               data_drv_q;
    logic               busy_q;
    logic               cmd_sent_q;
    logic               error_q;

    logic               clk_s1_q, clk_s2_q, clk_prev_q;
    logic               data_s1_q, data_s2_q;
    logic               fall;

    // Two-flop synchronisers plus the delayed clock used for edge detection.
    // Idle lines are high, so reset to 1 to avoid a false fall after reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            clk_prev_q <= 1'b1;
            data_s1_q  <= 1'b1;
            data_s2_q  <= 1'b1;
        end else begin
            clk_s1_q   <= ps2_clk_i;
            clk_s2_q   <= clk_s1_q;
            clk_prev_q <= clk_s2_q;
            data_s1_q  <= ps2_data_i;
            data_s2_q  <= data_s1_q;
        end
    end

    // Falling edge of the synchronised device clock.
    always_comb begin
        fall = clk_prev_q & ~clk_s2_q;
    end

    // Transfer FSM; every output is a register updated alongside the state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            tmr_q      <= '0;
            xfer_q     <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            ok_q       <= 1'b0;
            clk_drv_q  <= 1'b0;
            data_drv_q <= 1'b0;
            busy_q     <= 1'b0;
            cmd_sent_q <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            // Completion flags are single-cycle pulses.
            cmd_sent_q <= 1'b0;
            error_q    <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    clk_drv_q  <= 1'b0;
                    data_drv_q <= 1'b0;
                    if (send_cmd_i) begin
                        shift_q   <= cmd_byte_i;
                        parity_q  <= ~^cmd_byte_i;
                        busy_q    <= 1'b1;
                        clk_drv_q <= 1'b1;
                        tmr_q     <= '0;
                        state_q   <= StInhibit;
                    end
                end

                StInhibit: begin
                    if (tmr_q == InhibitLast) begin
                        // Start bit goes low in the same cycle clk is released.
                        data_drv_q <= 1'b1;
                        clk_drv_q  <= 1'b0;
                        tmr_q      <= '0;
                        state_q    <= StRts;
                    end else begin
                        tmr_q <= tmr_q + TmrW'(1);
                    end
                end

                StRts: begin
                    if (fall) begin
                        data_drv_q <= ~shift_q[0];
                        shift_q    <= {1'b0, shift_q[7:1]};
                        bit_cnt_q  <= '0;
                        xfer_q     <= '0;
                        state_q    <= StSendData;
                    end else if (tmr_q == StartLast) begin
                        clk_drv_q  <= 1'b0;
                        data_drv_q <= 1'b0;
                        busy_q     <= 1'b0;
                        error_q    <= 1'b1;
                        state_q    <= StAbort;
                    end else begin
                        tmr_q <= tmr_q + TmrW'(1);
                    end
                end

                StSendData, StSendParity, StSendStop, StWaitAck, StWaitRelease: begin
                    if (xfer_q == XferLast) begin
                        clk_drv_q  <= 1'b0;
                        data_drv_q <= 1'b0;
                        busy_q     <= 1'b0;
                        error_q    <= 1'b1;
                        state_q    <= StAbort;
                    end else begin
                        xfer_q <= xfer_q + XferW'(1);
                        case (state_q)
                            StSendData: begin
                                if (fall) begin
                                    if (bit_cnt_q == 3'd7) begin
                                        data_drv_q <= ~parity_q;
                                        state_q    <= StSendParity;
                                    end else begin
                                        data_drv_q <= ~shift_q[0];
                                        shift_q    <= {1'b0, shift_q[7:1]};
                                        bit_cnt_q  <= bit_cnt_q + 3'd1;
                                    end
                                end
                            end
                            StSendParity: begin
                                // Releasing data presents the stop bit.
                                if (fall) begin
                                    data_drv_q <= 1'b0;
                                    state_q    <= StSendStop;
                                end
                            end
                            StSendStop: begin
                                if (fall) begin
                                    state_q <= StWaitAck;
                                end
                            end
                            StWaitAck: begin
                                if (fall) begin
                                    ok_q    <= ~data_s2_q;
                                    state_q <= StWaitRelease;
                                end
                            end
                            StWaitRelease: begin
                                if (clk_s2_q && data_s2_q) begin
                                    cmd_sent_q <= ok_q;
                                    error_q    <= ~ok_q;
                                    busy_q     <= 1'b0;
                                    state_q    <= StIdle;
                                end
                            end
                            default: ;
                        endcase
                    end
                end

                StAbort: begin
                    // Lines, busy and error were already set on entry.
                    state_q <= StIdle;
                end

                default: begin
                    clk_drv_q  <= 1'b0;
                    data_drv_q <= 1'b0;
                    busy_q     <= 1'b0;
                    state_q    <= StIdle;
                end
            endcase
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        ps2_clk_drive_low_o  = clk_drv_q;
        ps2_data_drive_low_o = data_drv_q;
        busy_o               = busy_q;
        cmd_sent_o           = cmd_sent_q;
        error_o              = error_q;
    end

endmodule

// File: tb/tb_ps2_out.sv
// Bench for ps2_out: behavioural PS/2 device, frame reference model, timing checks.
module tb_ps2_out;

    localparam int unsigned INH = 50;
    localparam int unsigned STO = 400;
    localparam int unsigned XTO = 600;
    localparam int unsigned H   = 20;   // device clock half period in clk cycles

    logic       clk = 1'b0;
    logic       rst_n;
    logic       send_cmd;
    logic [7:0] cmd_byte;
    logic       dev_clk_low;
    logic       dev_data_low;
    logic       ps2_clk_line;
    logic       ps2_data_line;
    logic       clk_drv, data_drv, busy, cmd_sent, error;

    int checks = 0;
    int errors = 0;

    ps2_out #(
        .INHIBIT_CYCLES(INH),
        .START_TIMEOUT (STO),
        .XFER_TIMEOUT  (XTO)
    ) dut (
        .clk_i               (clk),
        .rst_ni              (rst_n),
        .send_cmd_i          (send_cmd),
        .cmd_byte_i          (cmd_byte),
        .ps2_clk_i           (ps2_clk_line),
        .ps2_data_i          (ps2_data_line),
        .ps2_clk_drive_low_o (clk_drv),
        .ps2_data_drive_low_o(data_drv),
        .busy_o              (busy),
        .cmd_sent_o          (cmd_sent),
        .error_o             (error)
    );

    // Open-drain wired-AND of host and device.
    assign ps2_clk_line  = ~(clk_drv | dev_clk_low);
    assign ps2_data_line = ~(data_drv | dev_data_low);

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pulse counts, timestamps and protocol invariants.
    int   n_sent = 0, n_err = 0, err_cyc = 0, rts_cyc = 0, lo_run = 0, lo_len = 0, viol = 0;
    logic err_prev = 1'b0, sent_prev = 1'b0;
    always @(negedge clk) begin
        err_prev  <= error;
        sent_prev <= cmd_sent;
        if (cmd_sent) n_sent <= n_sent + 1;
        if (error) begin
            n_err   <= n_err + 1;
            err_cyc <= cyc;
        end
        if ((cmd_sent && error) || ((cmd_sent || error) && busy) || (clk_drv && data_drv) ||
            (error && err_prev) || (cmd_sent && sent_prev))
            viol <= viol + 1;
        if (clk_drv) lo_run <= lo_run + 1;
        else if (lo_run != 0) begin
            lo_len  <= lo_run;
            lo_run  <= 0;
            rts_cyc <= cyc;
        end
    end

    int dev_falls = 0;
    int fall1_cyc = 0;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference frame: start 0, data LSB first, odd parity, stop 1 (bit 0 = start).
    function automatic logic [10:0] frame_of(input logic [7:0] b);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        return {1'b1, (ones % 2 == 0), b, 1'b0};
    endfunction

    // Device: waits for RTS, then clocks up to max_falls pulses, sampling on rising edges.
    task automatic device(input int max_falls, input bit ack,
                          output logic [10:0] cap, output bit rts_ok);
        cap       = '0;
        rts_ok    = 1'b0;
        dev_falls = 0;
        for (int w = 0; w < int'(INH) + 50; w++) begin
            @(negedge clk);
            if (!clk_drv && data_drv && busy) begin
                rts_ok = 1'b1;
                break;
            end
        end
        if (!rts_ok) return;
        cap[0] = ps2_data_line;
        for (int k = 1; k <= max_falls; k++) begin
            repeat (H) @(negedge clk);
            dev_clk_low = 1'b1;
            dev_falls++;
            if (k == 1) fall1_cyc = cyc;
            repeat (H) @(negedge clk);
            dev_clk_low = 1'b0;
            if (k <= 10) cap[k] = ps2_data_line;
            if (k == 10 && ack) dev_data_low = 1'b1;
            if (k == 12) dev_data_low = 1'b0;
        end
    endtask

    task automatic start_send(input logic [7:0] b);
        @(negedge clk);
        cmd_byte = b;
        send_cmd = 1'b1;
        @(negedge clk);
        send_cmd = 1'b0;
    endtask

    task automatic wait_idle(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        @(negedge clk);   // let monitor counters settle
    endtask

    logic [10:0] cap;
    logic [7:0]  rb;
    bit          rts_ok, idle_ok, rack;
    int          s0, e0;

    initial begin
        rst_n = 1'b0; send_cmd = 1'b0; cmd_byte = '0; dev_clk_low = 1'b0; dev_data_low = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_clk_drv", int'(clk_drv), 0);
        check("rst_data_drv", int'(data_drv), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_sent", int'(cmd_sent), 0);
        check("rst_error", int'(error), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // 1: 0xED acked
        s0 = n_sent; e0 = n_err;
        start_send(8'hED);
        check("t1_busy_up", int'(busy), 1);
        device(12, 1'b1, cap, rts_ok);
        wait_idle(200, idle_ok);
        check("t1_rts", int'(rts_ok), 1);
        check("t1_frame", int'(cap), int'(frame_of(8'hED)));
        check("t1_frame_lit", int'(cap), int'(11'b1_1_11101101_0));
        check("t1_sent", n_sent - s0, 1);
        check("t1_err", n_err - e0, 0);
        check("t1_idle", int'(idle_ok), 1);

        // 2: 0xFF then 0x00, both parity 1, inhibit length exact
        start_send(8'hFF);
        device(12, 1'b1, cap, rts_ok);
        wait_idle(200, idle_ok);
        check("t2a_frame", int'(cap), int'(frame_of(8'hFF)));
        check("t2a_parity", int'(cap[9]), 1);
        check("t2a_inhibit", lo_len, int'(INH));
        start_send(8'h00);
        device(12, 1'b1, cap, rts_ok);
        wait_idle(200, idle_ok);
        check("t2b_frame", int'(cap), int'(frame_of(8'h00)));
        check("t2b_parity", int'(cap[9]), 1);
        check("t2b_inhibit", lo_len, int'(INH));

        // 3: nack
        s0 = n_sent; e0 = n_err;
        start_send(8'h55);
        device(12, 1'b0, cap, rts_ok);
        wait_idle(200, idle_ok);
        check("t3_frame", int'(cap), int'(frame_of(8'h55)));
        check("t3_err", n_err - e0, 1);
        check("t3_sent", n_sent - s0, 0);
        check("t3_lines", int'({clk_drv, data_drv}), 0);
        check("t3_idle", int'(idle_ok), 1);

        // 4: device never clocks
        s0 = n_sent; e0 = n_err;
        start_send(8'hF0);
        device(0, 1'b1, cap, rts_ok);
        wait_idle(int'(STO) + 50, idle_ok);
        check("t4_rts", int'(rts_ok), 1);
        check("t4_err", n_err - e0, 1);
        check("t4_time", err_cyc - rts_cyc, int'(STO));
        check("t4_lines", int'({clk_drv, data_drv}), 0);
        check("t4_idle", int'(idle_ok), 1);

        // 5: device stops after bit3 (4 falls); sync+edge detect adds 3 cycles
        s0 = n_sent; e0 = n_err;
        start_send(8'h3C);
        device(4, 1'b1, cap, rts_ok);
        wait_idle(int'(XTO) + 100, idle_ok);
        check("t5_err", n_err - e0, 1);
        check("t5_sent", n_sent - s0, 0);
        check("t5_time", err_cyc - fall1_cyc, int'(XTO) + 3);
        check("t5_lines", int'({clk_drv, data_drv}), 0);

        // 6: reset during SEND_DATA, then a clean 0xF4
        start_send(8'hA7);
        fork
            device(4, 1'b1, cap, rts_ok);
            begin
                for (int i = 0; i < int'(INH) + 400 && dev_falls < 3; i++) @(negedge clk);
                check("t6_reached", int'(dev_falls >= 3), 1);
                repeat (5) @(negedge clk);
                check("t6_busy_before", int'(busy), 1);
                #2 rst_n = 1'b0;
                #1;
                check("t6_lines", int'({clk_drv, data_drv}), 0);
                check("t6_flags", int'({busy, cmd_sent, error}), 0);
            end
        join
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        dev_clk_low = 1'b0;
        dev_data_low = 1'b0;
        repeat (3) @(negedge clk);
        s0 = n_sent; e0 = n_err;
        start_send(8'hF4);
        device(12, 1'b1, cap, rts_ok);
        wait_idle(200, idle_ok);
        check("t6_frame", int'(cap), int'(frame_of(8'hF4)));
        check("t6_sent", n_sent - s0, 1);
        check("t6_err", n_err - e0, 0);

        // Random bytes with random ack/nack
        for (int r = 0; r < 4; r++) begin
            rb   = 8'($urandom);
            rack = 1'($urandom % 2);
            s0 = n_sent; e0 = n_err;
            start_send(rb);
            device(12, rack, cap, rts_ok);
            wait_idle(200, idle_ok);
            check("rnd_frame", int'(cap), int'(frame_of(rb)));
            check("rnd_sent", n_sent - s0, int'(rack));
            check("rnd_err", n_err - e0, int'(!rack));
        end

        check("invariants", viol, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
